// File: rtl/mseq_pkg.sv
// Shared definitions for the M-sequence modulation scheduler and its
// Signal_Modulation integration (pipeline latency must agree on both sides).
package mseq_pkg;

  localparam int MSEQ_PIPE_LAT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } mseq_state_e;

endpackage

// File: rtl/mseq_valid_delay.sv
// PIPE_LAT-deep {valid, last} delay line matching the mult/add/fix-to-float
// latency, so sig_valid/frame_last line up with Signal_Send.
module mseq_valid_delay
  import mseq_pkg::*;
#(
  parameter int PIPE_LAT = MSEQ_PIPE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  input  logic in_last,
  output logic out_vld,
  output logic out_last,
  output logic empty
);

  logic [PIPE_LAT:1] vld_pipe;
  logic [PIPE_LAT:1] last_pipe;
  logic              occupied;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= in_vld;
      last_pipe[1] <= in_vld & in_last;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // empty means the line holds nothing after the coming edge: the output
  // stage is leaving anyway, so only the input and inner stages matter.
  // This lets a registered done land right after the final sig_valid.
  always_comb begin
    occupied = in_vld;
    for (int i = 1; i < PIPE_LAT; i++) occupied = occupied | vld_pipe[i];
  end

  assign empty    = ~occupied;
  assign out_vld  = vld_pipe[PIPE_LAT];
  assign out_last = last_pipe[PIPE_LAT];

endmodule

// File: rtl/mseq_mod_scheduler.sv
// Frame sequencer: latches gain K per run, paces the M-sequence generator
// (reseed + advance) and produces valid/last aligned to Signal_Send.
module mseq_mod_scheduler
  import mseq_pkg::*;
#(
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int PIPE_LAT          = MSEQ_PIPE_LAT,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                         MSEQ_clk,
  input  logic                         MSEQ_rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [OUTPUT_DATA_WIDTH-1:0] cfg_k,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  input  logic [7:0]                   cfg_frames,
  output logic [OUTPUT_DATA_WIDTH-1:0] para_K,
  output logic                         mseq_load,
  output logic                         mseq_en,
  output logic                         sig_valid,
  output logic                         frame_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err_cfg
);

  mseq_state_e          state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [7:0]           frames_q;
  logic                 frame_end;
  logic                 tag;
  logic                 drained;

  assign frame_end = (cnt == len_q - 1'b1);
  // A stop cuts the frame short: the sample already on the wire becomes last.
  assign tag       = mseq_en & (frame_end | stop);

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      frames_q  <= '0;
      para_K    <= '0;
      mseq_load <= 1'b0;
      mseq_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      mseq_load <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_len == '0) begin
              err_cfg <= 1'b1;
            end else begin
              para_K    <= cfg_k;
              len_q     <= cfg_len;
              frames_q  <= cfg_frames;
              mseq_load <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          cnt <= '0;
          if (stop) begin
            state <= DRAIN;
          end else begin
            mseq_en <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (stop || frame_end) begin
            mseq_en <= 1'b0;
            // frames_q == 0 is continuous mode and never decrements
            if (frames_q != 8'd0) frames_q <= frames_q - 8'd1;
            if (!stop && frames_q != 8'd1) begin
              mseq_load <= 1'b1;
              state     <= LOAD;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mseq_valid_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_dly (
    .clk      (MSEQ_clk),
    .rst_n    (MSEQ_rst_n),
    .in_vld   (mseq_en),
    .in_last  (tag),
    .out_vld  (sig_valid),
    .out_last (frame_last),
    .empty    (drained)
  );

endmodule

// File: tb/tb_mseq_mod_scheduler.sv
// Directed, table-driven bench for mseq_mod_scheduler; each table row is one
// clock cycle of inputs plus the expected flags and para_K for that cycle.
module tb_mseq_mod_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_k = '0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_frames = '0;
  logic [15:0] para_K;
  logic        mseq_load, mseq_en, sig_valid, frame_last, busy, done, err_cfg;

  int errors = 0;
  int checks = 0;

  // flag order: {load, en, sig_valid, frame_last, done, busy, err_cfg}
  typedef struct {
    bit          st;
    bit          sp;
    logic [15:0] k;
    logic [15:0] len;
    logic [7:0]  fr;
    logic [6:0]  f;
    logic [15:0] ek;
  } vec_t;

  vec_t tbl[$];

  mseq_mod_scheduler #(
    .OUTPUT_DATA_WIDTH (16),
    .PIPE_LAT          (8),
    .LEN_WIDTH         (16)
  ) dut (
    .MSEQ_clk   (clk),
    .MSEQ_rst_n (rst_n),
    .start      (start),
    .stop       (stop),
    .cfg_k      (cfg_k),
    .cfg_len    (cfg_len),
    .cfg_frames (cfg_frames),
    .para_K     (para_K),
    .mseq_load  (mseq_load),
    .mseq_en    (mseq_en),
    .sig_valid  (sig_valid),
    .frame_last (frame_last),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] flags();
    return {mseq_load, mseq_en, sig_valid, frame_last, done, busy, err_cfg};
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic r(input bit st, input bit sp, input logic [15:0] k, input logic [15:0] len,
                   input logic [7:0] fr, input logic [6:0] f, input logic [15:0] ek);
    vec_t v;
    v.st = st; v.sp = sp; v.k = k; v.len = len; v.fr = fr; v.f = f; v.ek = ek;
    tbl.push_back(v);
  endtask

  task automatic span(input int n, input logic [6:0] f, input logic [15:0] ek);
    for (int i = 0; i < n; i++) r(1'b0, 1'b0, 16'h0, 16'h0, 8'h0, f, ek);
  endtask

  initial begin
    // single frame, len 4
    r(1, 0, 16'h0400, 16'd4, 8'd1, 7'b0000000, 16'h0000);
    span(1, 7'b1000010, 16'h0400);
    span(4, 7'b0100010, 16'h0400);
    span(4, 7'b0000010, 16'h0400);
    span(3, 7'b0010010, 16'h0400);
    span(1, 7'b0011010, 16'h0400);
    span(1, 7'b0000100, 16'h0400);
    span(1, 7'b0000000, 16'h0400);
    // two frames of 3
    r(1, 0, 16'h0A0B, 16'd3, 8'd2, 7'b0000000, 16'h0400);
    span(1, 7'b1000010, 16'h0A0B);
    span(3, 7'b0100010, 16'h0A0B);
    span(1, 7'b1000010, 16'h0A0B);
    span(3, 7'b0100010, 16'h0A0B);
    span(1, 7'b0000010, 16'h0A0B);
    span(2, 7'b0010010, 16'h0A0B);
    span(1, 7'b0011010, 16'h0A0B);
    span(1, 7'b0000010, 16'h0A0B);
    span(2, 7'b0010010, 16'h0A0B);
    span(1, 7'b0011010, 16'h0A0B);
    span(1, 7'b0000100, 16'h0A0B);
    span(1, 7'b0000000, 16'h0A0B);
    // continuous, len 2, stop on the 7th sample
    r(1, 0, 16'h0003, 16'd2, 8'd0, 7'b0000000, 16'h0A0B);
    span(1, 7'b1000010, 16'h0003);
    span(2, 7'b0100010, 16'h0003);
    span(1, 7'b1000010, 16'h0003);
    span(2, 7'b0100010, 16'h0003);
    span(1, 7'b1000010, 16'h0003);
    span(2, 7'b0100010, 16'h0003);
    span(1, 7'b1010010, 16'h0003);
    r(0, 1, 16'h0, 16'h0, 8'h0, 7'b0111010, 16'h0003);
    span(1, 7'b0000010, 16'h0003);
    span(1, 7'b0010010, 16'h0003);
    span(1, 7'b0011010, 16'h0003);
    span(1, 7'b0000010, 16'h0003);
    span(1, 7'b0010010, 16'h0003);
    span(1, 7'b0011010, 16'h0003);
    span(1, 7'b0000010, 16'h0003);
    span(1, 7'b0011010, 16'h0003);
    span(1, 7'b0000100, 16'h0003);
    span(1, 7'b0000000, 16'h0003);
    // zero length rejected
    r(1, 0, 16'h5555, 16'd0, 8'd1, 7'b0000000, 16'h0003);
    span(1, 7'b0000001, 16'h0003);
    span(1, 7'b0000000, 16'h0003);
    // start together with stop ignored
    r(1, 1, 16'h7777, 16'd4, 8'd1, 7'b0000000, 16'h0003);
    span(2, 7'b0000000, 16'h0003);
    // second start during RUN ignored
    r(1, 0, 16'h1234, 16'd2, 8'd1, 7'b0000000, 16'h0003);
    span(1, 7'b1000010, 16'h1234);
    span(1, 7'b0100010, 16'h1234);
    r(1, 0, 16'hBEEF, 16'd5, 8'd3, 7'b0100010, 16'h1234);
    span(6, 7'b0000010, 16'h1234);
    span(1, 7'b0010010, 16'h1234);
    span(1, 7'b0011010, 16'h1234);
    span(1, 7'b0000100, 16'h1234);
    span(2, 7'b0000000, 16'h1234);

    #23;
    chk("reset_flags", -1, {9'h0, flags()}, 16'h0);
    chk("reset_paraK", -1, para_K, 16'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      start = tbl[i].st; stop = tbl[i].sp; cfg_k = tbl[i].k;
      cfg_len = tbl[i].len; cfg_frames = tbl[i].fr;
      @(negedge clk);
      chk("flags", i, {9'h0, flags()}, {9'h0, tbl[i].f});
      chk("para_K", i, para_K, tbl[i].ek);
    end

    // async reset with samples in flight
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b0; cfg_k = 16'h4321; cfg_len = 16'd10; cfg_frames = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_en", 100, {15'h0, mseq_en}, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_flags", 101, {9'h0, flags()}, 16'h0);
    chk("async_paraK", 102, para_K, 16'h0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_reset_quiet", 103 + c, {9'h0, flags()}, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
